// File: rtl/axis_out_pkg.sv
// Shared types and helpers for the multi-lane AXI-Stream result streamer.
package axis_out_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_KEEP_W = 256;

  function automatic logic [63:0] ceil_div(input logic [63:0] num, input logic [63:0] den);
    return (num + den - 64'd1) / den;
  endfunction

  // Byte-enable mask of the final beat: rem == 0 means the beat is full.
  function automatic logic [MAX_KEEP_W-1:0] last_keep_mask(input int rem, input int lanes,
                                                           input int elem_w);
    logic [MAX_KEEP_W-1:0] m;
    int nbytes;
    nbytes = (rem == 0) ? (lanes * elem_w / 8) : (rem * elem_w / 8);
    m = '0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      if (i < nbytes) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_out_fifo.sv
// Synchronous FIFO holding {last, data} beats between the SRAM read port and m_axis.
module axis_out_fifo
  import axis_out_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is cleared on reset so an empty FIFO presents an all-zero head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/axi_stream_output_mc.sv
// Streams out_row*out_col elements from the output SRAM onto m_axis, LANES per beat.
// Optional stall counter enabled by defining AXIS_OUT_PERF_CNT_EN.
module axi_stream_output_mc
  import axis_out_pkg::*;
#(
  parameter int ADDR_WIDTH         = 13,
  parameter int DATA_WIDTH         = 8,
  parameter int LANES              = 4,
  parameter int FIFO_DEPTH         = 4,
  parameter int NUM_CHANNELS_WIDTH = 7
) (
  input  logic                                  m_axis_aclk,
  input  logic                                  m_axis_aresetn,
  input  logic                                  start,
  input  logic [ADDR_WIDTH-1:0]                 base_addr,
  input  logic [ADDR_WIDTH-1:0]                 out_row,
  input  logic [ADDR_WIDTH-1:0]                 out_col,
  input  logic [NUM_CHANNELS_WIDTH-1:0]         num_channels,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  sram_out_en,
  output logic [ADDR_WIDTH-1:0]                 sram_out_addr,
  input  logic [LANES*2*DATA_WIDTH-1:0]         sram_out_data_out,
  output logic [LANES*2*DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [LANES*2*DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready,
  output logic [NUM_CHANNELS_WIDTH-1:0]         m_axis_tuser,
  output logic [31:0]                           stall_cycles,
  output state_t                                state_dbg
);

  localparam int ELEM_W = 2 * DATA_WIDTH;
  localparam int WORD_W = LANES * ELEM_W;
  localparam int KEEP_W = WORD_W / 8;
  localparam int TOT_W  = 2 * ADDR_WIDTH;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  state_t                        state_q, state_d;
  logic [TOT_W-1:0]              total_q, beats_q, issued_q;
  logic [TOT_W-1:0]              total_in, beats_in;
  logic [ADDR_WIDTH-1:0]         base_q;
  logic [NUM_CHANNELS_WIDTH-1:0] tuser_q;
  logic                          inflight_q, rd_last_q;
  logic                          rd_en, rd_final, pop, accept;
  logic [CNT_W-1:0]              fifo_count;
  logic [WORD_W:0]               fifo_head;
  logic [KEEP_W-1:0]             last_keep;

  assign accept   = (state_q == IDLE) && start;
  assign total_in = TOT_W'(out_row) * TOT_W'(out_col);
  assign beats_in = TOT_W'(ceil_div(64'(total_in), 64'(LANES)));

  // A read is only issued when its returning word is guaranteed a FIFO slot.
  assign rd_en    = (state_q == FETCH) && (issued_q != beats_q) &&
                    ((fifo_count + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
  assign rd_final = rd_en && (issued_q == beats_q - 1'b1);

  // m_axis handshake: a beat transfers on any edge where tvalid && tready.
  // tvalid comes only from FIFO occupancy, and the head entry (data, keep,
  // last) plus the latched tuser cannot change until that beat is popped.
  assign pop = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (total_in == '0) ? DONE : FETCH;
      FETCH:   if (rd_final) state_d = DRAIN;
      DRAIN:   if (pop && fifo_head[WORD_W]) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q    <= IDLE;
      total_q    <= '0;
      beats_q    <= '0;
      issued_q   <= '0;
      base_q     <= '0;
      tuser_q    <= '0;
      inflight_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      rd_last_q  <= rd_final;
      if (accept) begin
        total_q  <= total_in;
        beats_q  <= beats_in;
        base_q   <= base_addr;
        tuser_q  <= num_channels;
        issued_q <= '0;
      end else if (rd_en) begin
        issued_q <= issued_q + 1'b1;
      end
    end
  end

  axis_out_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (m_axis_aclk),
    .rst_n     (m_axis_aresetn),
    .push      (inflight_q),
    .push_data ({rd_last_q, sram_out_data_out}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign last_keep = KEEP_W'(last_keep_mask(int'(total_q % TOT_W'(LANES)), LANES, ELEM_W));

  assign sram_out_en   = rd_en;
  assign sram_out_addr = base_q + issued_q[ADDR_WIDTH-1:0];
  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = fifo_head[WORD_W-1:0];
  assign m_axis_tlast  = m_axis_tvalid && fifo_head[WORD_W];
  assign m_axis_tkeep  = !m_axis_tvalid ? '0 : (fifo_head[WORD_W] ? last_keep : '1);
  assign m_axis_tuser  = tuser_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign state_dbg     = state_q;

`ifdef AXIS_OUT_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn)                       stall_q <= '0;
    else if (accept)                           stall_q <= '0;
    else if (m_axis_tvalid && !m_axis_tready)  stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_axi_stream_output_mc.sv
// Randomized self-checking bench for axi_stream_output_mc against a beat-level reference model.
module tb_axi_stream_output_mc;
  import axis_out_pkg::*;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int LANES = 4;
  localparam int DEPTH = 4;
  localparam int NCW   = 7;
  localparam int W     = LANES * 2 * DW;
  localparam int KW    = W / 8;
  localparam int BW    = NCW + 1 + KW + W;

  logic           clk, rst_n, start;
  logic [AW-1:0]  base_addr, out_row, out_col;
  logic [NCW-1:0] num_channels;
  logic           busy, done, sram_out_en;
  logic [AW-1:0]  sram_out_addr;
  logic [W-1:0]   sram_data, m_axis_tdata;
  logic [KW-1:0]  m_axis_tkeep;
  logic           m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [NCW-1:0] m_axis_tuser;
  logic [31:0]    stall_cycles;
  state_t         state_dbg;

  axi_stream_output_mc dut (
    .m_axis_aclk       (clk),
    .m_axis_aresetn    (rst_n),
    .start             (start),
    .base_addr         (base_addr),
    .out_row           (out_row),
    .out_col           (out_col),
    .num_channels      (num_channels),
    .busy              (busy),
    .done              (done),
    .sram_out_en       (sram_out_en),
    .sram_out_addr     (sram_out_addr),
    .sram_out_data_out (sram_data),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tuser      (m_axis_tuser),
    .stall_cycles      (stall_cycles),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- SRAM model ----------------
  logic [W-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (sram_out_en) sram_data <= mem[sram_out_addr];

  // ---------------- tready driver ----------------
  int ready_mode;  // 0: always ready, 1: random 50%, 2: held low
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] addr_q[$];
  int rd_cnt, hs_cnt, valid_cnt, done_cnt, occ_viol, stab_viol, stall_seen;
  logic          prev_stall;
  logic [BW-1:0] prev_beat, cur_beat;
  int checks, passed;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sram_out_en) begin
        addr_q.push_back(sram_out_addr);
        rd_cnt++;
      end
      cur_beat = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back(cur_beat);
        hs_cnt++;
      end
      if (m_axis_tvalid) valid_cnt++;
      if (m_axis_tvalid && !m_axis_tready) stall_seen++;
      if (done) done_cnt++;
      if (rd_cnt - hs_cnt > DEPTH) occ_viol++;
      if (prev_stall && (!m_axis_tvalid || cur_beat !== prev_beat)) stab_viol++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = cur_beat;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_mon();
    got_q.delete();
    addr_q.delete();
    rd_cnt = 0; hs_cnt = 0; valid_cnt = 0; done_cnt = 0;
    occ_viol = 0; stab_viol = 0; stall_seen = 0; prev_stall = 1'b0;
  endtask

  // Reference: beat k carries SRAM word (base+k) mod 2^AW; the last beat gets
  // tlast and, for a partial final word, keep bits only for the valid lanes.
  task automatic build_expected(input int base, input int row, input int col, input int nch);
    int total, beats, r;
    logic [AW-1:0] a;
    logic [KW-1:0] keep;
    total = row * col;
    beats = (total + LANES - 1) / LANES;
    r     = total % LANES;
    exp_q.delete();
    exp_addr_q.delete();
    for (int k = 0; k < beats; k++) begin
      a    = AW'((base + k) % (1 << AW));
      keep = (k == beats - 1 && r != 0) ? KW'((1 << (r * 2 * DW / 8)) - 1) : {KW{1'b1}};
      exp_addr_q.push_back(a);
      exp_q.push_back({NCW'(nch), (k == beats - 1), keep, mem[a]});
    end
  endtask

  function automatic int stream_errs();
    int e;
    e = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start(input int base, input int row, input int col, input int nch);
    build_expected(base, row, col, nch);
    @(posedge clk); #1;
    base_addr = AW'(base); out_row = AW'(row); out_col = AW'(col);
    num_channels = NCW'(nch); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom); out_row = AW'($urandom); out_col = AW'($urandom);
    num_channels = NCW'($urandom);
  endtask

  task automatic wait_done(input int budget, output logic seen);
    int n;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, m_axis_tuser} !== '0)
      $display("FAIL reset_axis: tvalid=%b tlast=%b tkeep=%h tdata=%h tuser=%h required all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, m_axis_tuser);
    else passed++;
    checks++;
    if ({sram_out_en, sram_out_addr, busy, done, stall_cycles} !== '0)
      $display("FAIL reset_ctrl: en=%b addr=%h busy=%b done=%b stall=%0d required all 0",
               sram_out_en, sram_out_addr, busy, done, stall_cycles);
    else passed++;
    checks++;
    if (state_dbg !== IDLE) $display("FAIL reset_state: got %0d required %0d", state_dbg, IDLE);
    else passed++;
    @(posedge clk); #3 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic seen;
    clear_mon(); ready_mode = 0;
    do_start(16'h10, 3, 4, 5);
    lat = 0;
    while (!m_axis_tvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 3) $display("FAIL basic_latency: first tvalid after %0d cycles required 3", lat);
    else passed++;
    wait_done(50, seen);
    checks++;
    if (!seen) $display("FAIL basic_done_timeout: done not seen, required within 50 cycles");
    else passed++;
    checks++;
    if (stream_errs() !== 0)
      $display("FAIL basic_stream: %0d errors, got %0d beats required %0d", stream_errs(), got_q.size(), exp_q.size());
    else passed++;
    checks++;
    if (addr_q !== exp_addr_q || addr_q.size() != 3)
      $display("FAIL basic_addrs: got %0d reads required 3 at 0x10..0x12", addr_q.size());
    else passed++;
    checks++;
    if (done_cnt !== 1) $display("FAIL basic_done_pulse: got %0d pulses required 1", done_cnt);
    else passed++;
  endtask

  task automatic test_partial_keep();
    logic seen;
    logic [BW-1:0] last_beat;
    clear_mon(); ready_mode = 0;
    do_start($urandom_range(0, 8000), 5, 1, $urandom_range(0, 127));
    wait_done(50, seen);
    checks++;
    if (stream_errs() !== 0 || !seen)
      $display("FAIL partial_stream: %0d errors, got %0d beats required 2, done=%b", stream_errs(), got_q.size(), seen);
    else passed++;
    last_beat = (got_q.size() == 2) ? got_q[1] : '0;
    checks++;
    if (last_beat[W+KW-1:W] !== 8'h03)
      $display("FAIL partial_keep: got %h required 03", last_beat[W+KW-1:W]);
    else passed++;
  endtask

  task automatic test_addr_wrap();
    logic seen;
    logic [AW-1:0] want[$];
    want = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    clear_mon(); ready_mode = 0;
    do_start(13'h1FFE, 4, 4, 9);
    wait_done(50, seen);
    checks++;
    if (addr_q !== want)
      $display("FAIL wrap_addrs: got %0d reads (first %h) required 1FFE,1FFF,0000,0001",
               addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 13'h0);
    else passed++;
    checks++;
    if (stream_errs() !== 0 || !seen)
      $display("FAIL wrap_stream: %0d errors, done=%b", stream_errs(), seen);
    else passed++;
  endtask

  task automatic test_zero_and_ignore();
    int lat;
    clear_mon(); ready_mode = 0;
    @(posedge clk); #1;
    base_addr = AW'($urandom); out_row = '0; out_col = AW'($urandom_range(1, 50));
    num_channels = NCW'($urandom); start = 1'b1;
    @(posedge clk); #1;
    out_row = 3; out_col = 4;  // start held: second request while busy
    lat = 0;
    @(negedge clk); if (done) lat = 1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); if (done && lat == 0) lat = 2;
    repeat (6) @(negedge clk);
    checks++;
    if (lat < 1 || lat > 2) $display("FAIL zero_done_latency: got %0d required 1..2", lat);
    else passed++;
    checks++;
    if (rd_cnt !== 0 || valid_cnt !== 0)
      $display("FAIL zero_no_activity: reads=%0d tvalid_cycles=%0d required 0/0", rd_cnt, valid_cnt);
    else passed++;
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0)
      $display("FAIL zero_ignore_start: done pulses=%0d busy=%b required 1/0", done_cnt, busy);
    else passed++;
  endtask

  task automatic test_random_backpressure();
    logic seen;
    int exp_stall;
    clear_mon(); ready_mode = 1;
    do_start($urandom_range(0, 8191), 16, 16, $urandom_range(0, 127));
    repeat (10) @(posedge clk);
    #1 start = 1'b1; base_addr = AW'($urandom); out_row = 2; out_col = 2;
    @(posedge clk); #1 start = 1'b0;
    wait_done(1000, seen);
    checks++;
    if (!seen || stream_errs() !== 0 || got_q.size() != 64)
      $display("FAIL random_stream: done=%b errors=%0d beats=%0d required 64", seen, stream_errs(), got_q.size());
    else passed++;
    checks++;
    if (stab_viol !== 0) $display("FAIL random_stable: %0d stall changes required 0", stab_viol);
    else passed++;
    checks++;
    if (occ_viol !== 0) $display("FAIL random_occupancy: %0d overfills required 0", occ_viol);
    else passed++;
`ifdef AXIS_OUT_PERF_CNT_EN
    exp_stall = stall_seen;
`else
    exp_stall = 0;
`endif
    checks++;
    if (stall_cycles !== 32'(exp_stall))
      $display("FAIL random_stall_cnt: got %0d required %0d", stall_cycles, exp_stall);
    else passed++;
    ready_mode = 0;
  endtask

  task automatic test_reset_midflight();
    int n, held;
    logic seen;
    clear_mon(); ready_mode = 2;
    @(posedge clk);
    do_start($urandom_range(0, 8191), 8, 16, 17);
    n = 0;
    while (rd_cnt - hs_cnt < DEPTH && n < 30) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    held = rd_cnt;
    checks++;
    if (held !== DEPTH || !m_axis_tvalid)
      $display("FAIL full_stall: reads=%0d tvalid=%b required %0d/1", held, m_axis_tvalid, DEPTH);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, m_axis_tuser,
         sram_out_en, sram_out_addr, busy, done, stall_cycles} !== '0)
      $display("FAIL midreset_outputs: tvalid=%b tdata=%h en=%b busy=%b required all 0",
               m_axis_tvalid, m_axis_tdata, sram_out_en, busy);
    else passed++;
    @(posedge clk); #3 rst_n = 1'b1;
    clear_mon(); ready_mode = 0;
    do_start($urandom_range(0, 8191), 3, 5, 33);
    wait_done(60, seen);
    checks++;
    if (!seen || stream_errs() !== 0 || got_q.size() != 4)
      $display("FAIL post_reset_stream: done=%b errors=%0d beats=%0d required 4", seen, stream_errs(), got_q.size());
    else passed++;
  endtask

  task automatic test_perf_stalls();
    int n, exp_stall;
    logic seen;
    clear_mon(); ready_mode = 2;
    @(posedge clk);
    do_start($urandom_range(0, 8191), 3, 4, 2);
    n = 0;
    while (!m_axis_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    ready_mode = 0;
    wait_done(50, seen);
    repeat (4) @(negedge clk);
`ifdef AXIS_OUT_PERF_CNT_EN
    exp_stall = 7;
`else
    exp_stall = 0;
`endif
    checks++;
    if (stall_cycles !== 32'(exp_stall))
      $display("FAIL perf_stalls: got %0d required %0d", stall_cycles, exp_stall);
    else passed++;
    checks++;
    if (!seen || stream_errs() !== 0)
      $display("FAIL perf_stream: done=%b errors=%0d", seen, stream_errs());
    else passed++;
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    checks = 0; passed = 0;
    rst_n = 1'b0; start = 1'b0; ready_mode = 2; m_axis_tready = 1'b0;
    base_addr = '0; out_row = '0; out_col = '0; num_channels = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
    clear_mon();
    test_reset();
    test_basic();
    test_partial_keep();
    test_addr_wrap();
    test_zero_and_ignore();
    test_random_backpressure();
    test_reset_midflight();
    test_perf_stalls();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
